// File: rtl/instruction_fetcher_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// Cache geometry is derived here so the array and the FSM agree on the field split.
package instruction_fetcher_pkg;

  localparam int ICACHE_LINES = 64;
  localparam int INDEX_W      = $clog2(ICACHE_LINES);
  localparam int TAG_W        = 30 - INDEX_W;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_MISS  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetcher_icache_array.sv
// Direct-mapped, one-word-per-line instruction cache storage.
// Combinational lookup, synchronous fill; only valid bits are cleared by reset.
module icache_array
  import instruction_fetcher_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [INDEX_W-1:0] rd_index_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  output logic               rd_hit_o,
  output logic [31:0]        rd_data_o,
  input  logic               we_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [31:0]        wr_data_i
);

  logic [ICACHE_LINES-1:0] valid_q;
  logic [ICACHE_LINES-1:0] wr_sel;
  logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];

  genvar gi;
  generate
    for (gi = 0; gi < ICACHE_LINES; gi++) begin : g_wr_sel
      assign wr_sel[gi] = we_i && (wr_index_i == INDEX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_q | wr_sel;
    end
  end

  // Tag and data are plain RAM; a cleared valid bit is enough to invalidate a line.
  always_ff @(posedge clk_in) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_hit_o  = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_index_i];

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: looks the predictor's PC up in the I-cache, fills misses from the
// memory controller and emits one instruction pulse per PC to the decoder queue.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_in,
  input  logic        stop_fetching,
  input  logic        roll_back,
  input  logic        iq_full,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
);

  fetch_state_e state_q, state_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  inst_out_q, inst_out_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         mc_req_q, mc_req_d;
  logic [31:0]  mc_addr_q, mc_addr_d;

  logic         fill_en;
  logic         cache_hit;
  logic [31:0]  cache_data;
  logic         lookup_ok;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^{pc_in[1:0], mc_addr_q[1:0]};

  icache_array u_icache (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rd_index_i (pc_in[INDEX_W+1:2]),
    .rd_tag_i   (pc_in[31:INDEX_W+2]),
    .rd_hit_o   (cache_hit),
    .rd_data_o  (cache_data),
    .we_i       (fill_en && rdy_in),
    .wr_index_i (mc_addr_q[INDEX_W+1:2]),
    .wr_tag_i   (mc_addr_q[31:INDEX_W+2]),
    .wr_data_i  (mc_data)
  );

  // Skipping the cycle right after an emission lets the predictor advance pc_in.
  assign lookup_ok = !stop_fetching && !iq_full && !roll_back && !inst_valid_q;

  always_comb begin
    state_d      = state_q;
    inst_valid_d = FALSE;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    mc_req_d     = mc_req_q;
    mc_addr_d    = mc_addr_q;
    fill_en      = FALSE;
    case (state_q)
      FETCH_IDLE: begin
        if (lookup_ok) begin
          if (cache_hit) begin
            inst_valid_d = TRUE;
            inst_out_d   = cache_data;
            inst_pc_d    = pc_in;
          end else begin
            mc_addr_d = pc_in;
            mc_req_d  = TRUE;
            state_d   = FETCH_MISS;
          end
        end
      end
      FETCH_MISS: begin
        if (mc_done) begin
          fill_en  = TRUE;
          mc_req_d = FALSE;
          state_d  = FETCH_IDLE;
          if (!roll_back) begin
            inst_valid_d = TRUE;
            inst_out_d   = mc_data;
            inst_pc_d    = mc_addr_q;
          end
        end else if (roll_back) begin
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        // The returning word is still correct for mc_addr, so keep it in the cache.
        if (mc_done) begin
          fill_en  = TRUE;
          mc_req_d = FALSE;
          state_d  = FETCH_IDLE;
        end
      end
      default: begin
        state_d  = FETCH_IDLE;
        mc_req_d = FALSE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= FETCH_IDLE;
      inst_valid_q <= FALSE;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      mc_req_q     <= FALSE;
      mc_addr_q    <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      mc_req_q     <= mc_req_d;
      mc_addr_q    <= mc_addr_d;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign mc_req     = mc_req_q;
  assign mc_addr    = mc_addr_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed table, multi-cycle corner
// sequences and randomized fetches against a tag-store model of the cache.
module tb_instruction_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, stop_fetching, roll_back, iq_full;
  logic [31:0] pc_in;
  logic        inst_valid, mc_req;
  logic [31:0] inst_out, inst_pc, mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;

  logic        auto_done = 1'b0;
  logic [31:0] auto_data = '0;
  logic        man_done  = 1'b0;
  logic [31:0] man_data  = '0;
  bit          resp_en   = 1'b1;
  int          resp_lat  = 5;
  int          resp_cnt  = 0;

  int n_cmp = 0;
  int n_err = 0;

  bit          mv [64];
  logic [23:0] mt [64];

  assign mc_done = auto_done | man_done;
  assign mc_data = man_done ? man_data : auto_data;

  always #5 clk_in = ~clk_in;

  instruction_fetcher dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .pc_in         (pc_in),
    .stop_fetching (stop_fetching),
    .roll_back     (roll_back),
    .iq_full       (iq_full),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .mc_req        (mc_req),
    .mc_addr       (mc_addr),
    .mc_done       (mc_done),
    .mc_data       (mc_data)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0513;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Memory controller: one-cycle done pulse resp_lat cycles after the request is seen.
  always @(negedge clk_in) begin
    auto_done = 1'b0;
    if (mc_req && resp_en) begin
      resp_cnt++;
      if (resp_cnt >= resp_lat) begin
        auto_done = 1'b1;
        auto_data = mem_word(mc_addr);
        resp_cnt  = 0;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] pc);
    logic [5:0] idx;
    idx = pc[7:2];
    return mv[idx] && (mt[idx] == pc[31:8]);
  endfunction

  task automatic model_fill(input logic [31:0] pc);
    logic [5:0] idx;
    idx = pc[7:2];
    mv[idx] = 1'b1;
    mt[idx] = pc[31:8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  task automatic wait_emit(input logic [31:0] pc, input string nm);
    int k = 0;
    int done_at = -1;
    while (!inst_valid && k < 100) begin
      if (mc_done) done_at = k;
      step();
      k++;
    end
    check({nm, "_valid"}, {31'b0, inst_valid}, 32'd1);
    check({nm, "_lat_after_done"}, done_at, k - 1);
    check({nm, "_data"}, inst_out, mem_word(pc));
    check({nm, "_pc"}, inst_pc, pc);
    model_fill(pc);
  endtask

  task automatic fetch(input logic [31:0] pc, input bit exp_hit, input string nm);
    stop_fetching = 1'b0;
    iq_full       = 1'b0;
    roll_back     = 1'b0;
    pc_in         = pc;
    if (inst_valid) step();
    step();
    if (exp_hit) begin
      check({nm, "_hit_valid"}, {31'b0, inst_valid}, 32'd1);
      check({nm, "_hit_noreq"}, {31'b0, mc_req}, 32'd0);
      if (inst_valid) begin
        check({nm, "_hit_data"}, inst_out, mem_word(pc));
        check({nm, "_hit_pc"}, inst_pc, pc);
        model_fill(pc);
      end
    end else begin
      check({nm, "_miss_req"}, {31'b0, mc_req}, 32'd1);
      check({nm, "_miss_addr"}, mc_addr, pc);
      check({nm, "_miss_noemit"}, {31'b0, inst_valid}, 32'd0);
    end
    if (!inst_valid) wait_emit(pc, nm);
    $display("fetch %-12s pc=%h expect_hit=%0d inst=%h", nm, pc, exp_hit, inst_out);
  endtask

  typedef struct {
    logic [31:0] pc;
    bit          hit;
  } vec_t;

  vec_t vecs [9];
  logic [31:0] rpc, save_pc;
  int k;

  initial begin
    vecs[0] = '{32'h000, 1'b0};  // cold miss
    vecs[1] = '{32'h000, 1'b1};
    vecs[2] = '{32'h004, 1'b0};
    vecs[3] = '{32'h104, 1'b0};  // same index, different tag
    vecs[4] = '{32'h004, 1'b0};  // evicted by 0x104
    vecs[5] = '{32'h004, 1'b1};
    vecs[6] = '{32'h104, 1'b0};
    vecs[7] = '{32'h008, 1'b0};
    vecs[8] = '{32'h008, 1'b1};

    rst_in = 1'b1; rdy_in = 1'b1; stop_fetching = 1'b1; roll_back = 1'b0;
    iq_full = 1'b0; pc_in = 32'h0;
    model_clear();
    repeat (3) step();
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_out", inst_out, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_req", {31'b0, mc_req}, 32'd0);
    check("rst_addr", mc_addr, 32'd0);
    rst_in = 1'b0;
    step();
    check("post_rst_idle_req", {31'b0, mc_req}, 32'd0);

    resp_lat = 5;
    for (int i = 0; i < 9; i++) fetch(vecs[i].pc, vecs[i].hit, $sformatf("vec%0d", i));

    // Roll_back during MISS: drained word is cached but never emitted.
    resp_lat = 4;
    stop_fetching = 1'b0; iq_full = 1'b0; pc_in = 32'h20;
    if (inst_valid) step();
    step();
    check("rb_req", {31'b0, mc_req}, 32'd1);
    check("rb_addr", mc_addr, 32'h20);
    roll_back = 1'b1;
    step();
    roll_back = 1'b0;
    pc_in = 32'h40;
    k = 0;
    while (mc_req && k < 50) begin
      check("rb_drain_noemit", {31'b0, inst_valid}, 32'd0);
      check("rb_drain_addr", mc_addr, 32'h20);
      step();
      k++;
    end
    check("rb_drain_done", {31'b0, mc_req}, 32'd0);
    check("rb_drain_final_noemit", {31'b0, inst_valid}, 32'd0);
    model_fill(32'h20);
    $display("drain     pc=00000020 cycles=%0d", k);
    fetch(32'h40, 1'b0, "rb_new");
    fetch(32'h20, 1'b1, "rb_refetch");

    // Roll_back in the same cycle as mc_done: fill without emission.
    resp_lat = 3;
    pc_in = 32'h80;
    if (inst_valid) step();
    step();
    k = 0;
    while (!mc_done && k < 20) begin step(); k++; end
    roll_back = 1'b1;
    step();
    roll_back = 1'b0;
    check("rbdone_noemit", {31'b0, inst_valid}, 32'd0);
    check("rbdone_noreq", {31'b0, mc_req}, 32'd0);
    model_fill(32'h80);
    $display("rb+done   pc=00000080");
    fetch(32'h80, 1'b1, "rbdone_ref");

    // Back-pressure: no lookup while iq_full or stop_fetching.
    iq_full = 1'b1; pc_in = 32'h300;
    step();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin iq_full = 1'b0; stop_fetching = 1'b1; end
      step();
      check("bp_noemit", {31'b0, inst_valid}, 32'd0);
      check("bp_noreq", {31'b0, mc_req}, 32'd0);
    end
    $display("backpress pc=00000300 held 6 cycles");
    fetch(32'h300, 1'b0, "bp_release");

    // Reset mid-MISS, then a stale mc_done.
    resp_en = 1'b0;
    pc_in = 32'h400;
    if (inst_valid) step();
    step();
    check("rstmiss_req", {31'b0, mc_req}, 32'd1);
    rst_in = 1'b1; stop_fetching = 1'b1;
    step();
    rst_in = 1'b0;
    model_clear();
    check("rstmiss_noreq", {31'b0, mc_req}, 32'd0);
    check("rstmiss_addr", mc_addr, 32'd0);
    man_done = 1'b1; man_data = 32'hDEAD_BEEF;
    step();
    man_done = 1'b0;
    check("stale_noemit", {31'b0, inst_valid}, 32'd0);
    check("stale_noreq", {31'b0, mc_req}, 32'd0);
    resp_en = 1'b1;
    $display("reset     mid-miss pc=00000400");
    fetch(32'h000, 1'b0, "rst_refetch");

    // Pause during MISS, then pause while an emission pulse is up.
    resp_en = 1'b0;
    pc_in = 32'h500;
    if (inst_valid) step();
    step();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pause_req", {31'b0, mc_req}, 32'd1);
      check("pause_addr", mc_addr, 32'h500);
      check("pause_noemit", {31'b0, inst_valid}, 32'd0);
    end
    rdy_in = 1'b1; resp_en = 1'b1; resp_lat = 2;
    wait_emit(32'h500, "pause_fill");
    save_pc = inst_pc;
    rdy_in = 1'b0;
    step();
    check("pause_pulse_held", {31'b0, inst_valid}, 32'd1);
    check("pause_pulse_pc", inst_pc, save_pc);
    rdy_in = 1'b1;
    step();
    check("pause_pulse_drop", {31'b0, inst_valid}, 32'd0);
    $display("pause     pc=00000500");

    // Randomized fetches over a small address space with conflicts.
    for (int it = 0; it < 150; it++) begin
      rpc = {22'h0, 2'($urandom_range(0, 2)), 6'($urandom_range(0, 7)), 2'b00};
      resp_lat = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) begin
        iq_full = 1'b1; pc_in = rpc;
        step();
        step();
        check("rnd_bp_noemit", {31'b0, inst_valid}, 32'd0);
        check("rnd_bp_noreq", {31'b0, mc_req}, 32'd0);
      end
      fetch(rpc, model_hit(rpc), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
